// File: rtl/microsequencer_pkg.sv
// Shared opcode and control-state encodings for the microsequencer and its users.
package microsequencer_pkg;

  localparam int OPCODE_WIDTH   = 4;
  localparam int STATE_WIDTH    = 4;
  localparam int CYCLE_WIDTH    = 4;
  localparam int MAX_CYCLES_DEF = 8;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_OUT = 4'h5,
    OP_JMP = 4'h6,
    OP_JZ  = 4'h7,
    OP_JC  = 4'h8,
    OP_HLT = 4'h9
  } opcode_e;

  typedef enum logic [STATE_WIDTH-1:0] {
    STATE_FETCH_PC   = 4'd0,
    STATE_FETCH_INST = 4'd1,
    STATE_FETCH_ARG  = 4'd2,
    STATE_LOAD_Z     = 4'd3,
    STATE_RAM_A      = 4'd4,
    STATE_RAM_B      = 4'd5,
    STATE_ALU        = 4'd6,
    STATE_OUT_A      = 4'd7,
    STATE_HALT       = 4'd8,
    STATE_JUMP_Z     = 4'd9,
    STATE_NEXT       = 4'd10,
    STATE_STORE_A    = 4'd11
  } state_e;

  function automatic logic op_is_legal(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA,
      OP_OUT, OP_JMP, OP_JZ, OP_JC, OP_HLT: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/microsequencer_if.sv
// Control bus between the instruction register/flags side and the microsequencer.
interface microsequencer_if
  import microsequencer_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_WIDTH,
  parameter int STATE_W  = STATE_WIDTH,
  parameter int CYCLE_W  = CYCLE_WIDTH
) ();

  logic                ready;
  logic [OPCODE_W-1:0] opcode_in;
  logic                flag_z;
  logic                flag_c;
  logic                resume;

  logic [STATE_W-1:0]  state;
  logic [CYCLE_W-1:0]  cycle;
  logic [OPCODE_W-1:0] opcode;
  logic                halted;
  logic                instr_done;
  logic                illegal_op;
  logic                seq_error;

  modport master (
    output ready, opcode_in, flag_z, flag_c, resume,
    input  state, cycle, opcode, halted, instr_done, illegal_op, seq_error
  );

  modport slave (
    input  ready, opcode_in, flag_z, flag_c, resume,
    output state, cycle, opcode, halted, instr_done, illegal_op, seq_error
  );

endinterface

// File: rtl/microsequencer_cycle_counter.sv
// Micro-cycle index counter: synchronous clear has priority over increment.
module cycle_counter #(
  parameter int CYCLE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic               clr_i,
  output logic [CYCLE_W-1:0] cnt_o
);

  logic [CYCLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CYCLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/microsequencer.sv
// Variable-length instruction sequencer: decodes (cycle, latched opcode, flags) into a
// control state, retiring at STATE_NEXT, with stall, resumable halt and watchdog.
module microsequencer
  import microsequencer_pkg::*;
#(
  parameter int OPCODE_W   = OPCODE_WIDTH,
  parameter int STATE_W    = STATE_WIDTH,
  parameter int CYCLE_W    = CYCLE_WIDTH,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input logic             clk,
  input logic             reset_n,
  microsequencer_if.slave bus
);

  localparam logic [CYCLE_W-1:0] C0   = CYCLE_W'(0);
  localparam logic [CYCLE_W-1:0] C1   = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] C2   = CYCLE_W'(2);
  localparam logic [CYCLE_W-1:0] C3   = CYCLE_W'(3);
  localparam logic [CYCLE_W-1:0] C4   = CYCLE_W'(4);
  localparam logic [CYCLE_W-1:0] C5   = CYCLE_W'(5);
  localparam logic [CYCLE_W-1:0] C6   = CYCLE_W'(6);
  localparam logic [CYCLE_W-1:0] LAST = CYCLE_W'(MAX_CYCLES - 1);

  logic [CYCLE_W-1:0]  cycle;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic                illegal_q, illegal_d;
  logic                seq_err_q, seq_err_d;
  logic [STATE_W-1:0]  dec_state, state;
  logic                watchdog_hit, advance, at_next;

  cycle_counter #(.CYCLE_W(CYCLE_W)) u_cycle_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (advance),
    .clr_i   (advance && at_next),
    .cnt_o   (cycle)
  );

  // Any (cycle, opcode) pair not listed falls through to NEXT, so outputs never go X.
  always_comb begin
    dec_state = STATE_NEXT;
    if (cycle == C0) begin
      dec_state = STATE_FETCH_PC;
    end else if (cycle == C1) begin
      dec_state = STATE_FETCH_INST;
    end else begin
      case (opcode_q)
        OP_OUT: if (cycle == C2) dec_state = STATE_OUT_A;
        OP_HLT: if (cycle == C2) dec_state = STATE_HALT;
        OP_JMP: begin
          if (cycle == C2)      dec_state = STATE_FETCH_PC;
          else if (cycle == C3) dec_state = STATE_JUMP_Z;
        end
        OP_JZ: begin
          if (cycle == C2)                dec_state = STATE_FETCH_PC;
          else if (cycle == C3 && bus.flag_z) dec_state = STATE_JUMP_Z;
        end
        OP_JC: begin
          if (cycle == C2)                dec_state = STATE_FETCH_PC;
          else if (cycle == C3 && bus.flag_c) dec_state = STATE_JUMP_Z;
        end
        OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
          if (cycle == C2)      dec_state = STATE_FETCH_PC;
          else if (cycle == C3) dec_state = STATE_FETCH_ARG;
          else if (cycle == C4) dec_state = STATE_LOAD_Z;
          else if (cycle == C5) begin
            if (opcode_q == OP_LDA)      dec_state = STATE_RAM_A;
            else if (opcode_q == OP_STA) dec_state = STATE_STORE_A;
            else                         dec_state = STATE_RAM_B;
          end else if (cycle == C6 && (opcode_q == OP_ADD || opcode_q == OP_SUB)) begin
            dec_state = STATE_ALU;
          end
        end
        default: dec_state = STATE_NEXT;
      endcase
    end
  end

  always_comb begin
    watchdog_hit = (cycle == LAST) && (dec_state != STATE_NEXT);
    state        = watchdog_hit ? STATE_NEXT : dec_state;
    at_next      = (state == STATE_NEXT);
    advance      = bus.ready && ((state != STATE_HALT) || bus.resume);

    opcode_d = opcode_q;
    if (advance && cycle == C1) begin
      opcode_d = bus.opcode_in;
    end
    illegal_d = illegal_q || (advance && cycle == C2 && !op_is_legal(opcode_q));
    seq_err_d = seq_err_q || (advance && watchdog_hit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_q  <= OP_NOP;
      illegal_q <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign bus.state      = state;
  assign bus.cycle      = cycle;
  assign bus.opcode     = opcode_q;
  assign bus.halted     = (state == STATE_HALT);
  assign bus.instr_done = at_next && bus.ready;
  assign bus.illegal_op = illegal_q;
  assign bus.seq_error  = seq_err_q;

endmodule

// File: tb/tb_microsequencer.sv
// Table-driven bench for microsequencer: per-cycle rows go through a scoreboard queue,
// plus a hand-written asynchronous reset in the middle of an ADD.
module tb_microsequencer;
  import microsequencer_pkg::*;

  typedef struct {
    logic       rdy;
    logic [3:0] op_in;
    logic       fz;
    logic       fc;
    logic       res;
    logic [3:0] st;
    logic [3:0] cyc;
    logic       done;
    logic       halt;
    logic [3:0] op;
    logic       ill;
  } vec_t;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  vec_t sb[$];

  microsequencer_if bus ();

  microsequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rdy, input logic [3:0] op_in, input logic fz, input logic fc,
                     input logic res, input logic [3:0] st, input logic [3:0] cyc,
                     input logic done, input logic halt, input logic [3:0] op, input logic ill);
    vec_t v;
    v.rdy = rdy; v.op_in = op_in; v.fz = fz; v.fc = fc; v.res = res;
    v.st = st; v.cyc = cyc; v.done = done; v.halt = halt; v.op = op; v.ill = ill;
    vecs.push_back(v);
  endtask

  // seq lists the state of each cycle in order, one nibble per cycle, first cycle leftmost.
  task automatic add_seq(input logic [3:0] op, input logic [3:0] prev, input logic fz,
                         input logic fc, input logic res, input logic ill,
                         input int n, input logic [31:0] seq);
    for (int i = 0; i < n; i++) begin
      add(1'b1, op, fz, fc, res, seq[4*(n-1-i) +: 4], 4'(i), (i == n - 1), 1'b0,
          (i < 2) ? prev : op, ill);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_ill);
    chk({tag, "_state"},  32'(bus.state),      32'(STATE_FETCH_PC));
    chk({tag, "_cycle"},  32'(bus.cycle),      32'd0);
    chk({tag, "_opcode"}, 32'(bus.opcode),     32'(OP_NOP));
    chk({tag, "_halted"}, 32'(bus.halted),     32'd0);
    chk({tag, "_done"},   32'(bus.instr_done), 32'd0);
    chk({tag, "_ill"},    32'(bus.illegal_op), 32'(exp_ill));
    chk({tag, "_seqerr"}, 32'(bus.seq_error),  32'd0);
  endtask

  initial begin
    vec_t e;
    int   row;
    reset_n = 1'b0;
    bus.ready = 1'b0; bus.opcode_in = OP_NOP; bus.flag_z = 1'b0; bus.flag_c = 1'b0;
    bus.resume = 1'b0;

    add_seq(OP_LDA, OP_NOP, 0, 0, 0, 0, 7, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_FETCH_ARG, STATE_LOAD_Z, STATE_RAM_A, STATE_NEXT}));
    add(1, OP_ADD, 0, 0, 0, STATE_FETCH_PC,   0, 0, 0, OP_LDA, 0);
    add(1, OP_ADD, 0, 0, 0, STATE_FETCH_INST, 1, 0, 0, OP_LDA, 0);
    add(1, OP_ADD, 0, 0, 0, STATE_FETCH_PC,   2, 0, 0, OP_ADD, 0);
    add(1, OP_ADD, 0, 0, 0, STATE_FETCH_ARG,  3, 0, 0, OP_ADD, 0);
    add(1, OP_ADD, 0, 0, 0, STATE_LOAD_Z,     4, 0, 0, OP_ADD, 0);
    add(0, OP_OUT, 0, 0, 1, STATE_RAM_B,      5, 0, 0, OP_ADD, 0);
    add(0, OP_OUT, 0, 0, 0, STATE_RAM_B,      5, 0, 0, OP_ADD, 0);
    add(0, OP_OUT, 0, 0, 0, STATE_RAM_B,      5, 0, 0, OP_ADD, 0);
    add(1, OP_ADD, 0, 0, 0, STATE_RAM_B,      5, 0, 0, OP_ADD, 0);
    add(1, OP_ADD, 0, 0, 0, STATE_ALU,        6, 0, 0, OP_ADD, 0);
    add(1, OP_ADD, 0, 0, 0, STATE_NEXT,       7, 1, 0, OP_ADD, 0);
    add_seq(OP_SUB, OP_ADD, 0, 0, 0, 0, 8, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_FETCH_ARG, STATE_LOAD_Z, STATE_RAM_B, STATE_ALU, STATE_NEXT}));
    add_seq(OP_STA, OP_SUB, 0, 0, 0, 0, 7, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_FETCH_ARG, STATE_LOAD_Z, STATE_STORE_A, STATE_NEXT}));
    add_seq(OP_OUT, OP_STA, 0, 0, 1, 0, 4, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_OUT_A, STATE_NEXT}));
    add_seq(OP_JMP, OP_OUT, 0, 0, 0, 0, 5, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_JUMP_Z, STATE_NEXT}));
    add_seq(OP_JZ, OP_JMP, 0, 1, 0, 0, 4, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_NEXT}));
    add_seq(OP_JZ, OP_JZ, 1, 0, 0, 0, 5, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_JUMP_Z, STATE_NEXT}));
    add_seq(OP_JC, OP_JZ, 1, 0, 0, 0, 4, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_NEXT}));
    add_seq(OP_JC, OP_JC, 0, 1, 0, 0, 5, 32'({STATE_FETCH_PC, STATE_FETCH_INST,
            STATE_FETCH_PC, STATE_JUMP_Z, STATE_NEXT}));
    add_seq(OP_NOP, OP_JC, 0, 0, 0, 0, 3, 32'({STATE_FETCH_PC, STATE_FETCH_INST, STATE_NEXT}));
    add(1, OP_HLT, 0, 0, 1, STATE_FETCH_PC,   0, 0, 0, OP_NOP, 0);
    add(1, OP_HLT, 0, 0, 1, STATE_FETCH_INST, 1, 0, 0, OP_NOP, 0);
    for (int i = 0; i < 10; i++) add(1, OP_HLT, 0, 0, 0, STATE_HALT, 2, 0, 1, OP_HLT, 0);
    add(0, OP_HLT, 0, 0, 1, STATE_HALT, 2, 0, 1, OP_HLT, 0);
    add(1, OP_HLT, 0, 0, 1, STATE_HALT, 2, 0, 1, OP_HLT, 0);
    add(1, OP_HLT, 0, 0, 0, STATE_NEXT, 3, 1, 0, OP_HLT, 0);
    add_seq(4'hF, OP_HLT, 0, 0, 0, 0, 3, 32'({STATE_FETCH_PC, STATE_FETCH_INST, STATE_NEXT}));
    add_seq(OP_NOP, 4'hF, 0, 0, 0, 1, 3, 32'({STATE_FETCH_PC, STATE_FETCH_INST, STATE_NEXT}));

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #4 chk_idle("reset", 1'b0);

    row = 0;
    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      bus.ready = vecs[k].rdy; bus.opcode_in = vecs[k].op_in;
      bus.flag_z = vecs[k].fz; bus.flag_c = vecs[k].fc; bus.resume = vecs[k].res;
      sb.push_back(vecs[k]);
      #4;
      e = sb.pop_front();
      chk($sformatf("row%0d_state", row),  32'(bus.state),      32'(e.st));
      chk($sformatf("row%0d_cycle", row),  32'(bus.cycle),      32'(e.cyc));
      chk($sformatf("row%0d_done", row),   32'(bus.instr_done), 32'(e.done));
      chk($sformatf("row%0d_halted", row), 32'(bus.halted),     32'(e.halt));
      chk($sformatf("row%0d_opcode", row), 32'(bus.opcode),     32'(e.op));
      chk($sformatf("row%0d_ill", row),    32'(bus.illegal_op), 32'(e.ill));
      chk($sformatf("row%0d_seqerr", row), 32'(bus.seq_error),  32'd0);
      row++;
    end

    // Reset asserted between clock edges while an ADD sits in cycle 5.
    @(posedge clk);
    #1 bus.ready = 1'b1; bus.opcode_in = OP_ADD; bus.resume = 1'b0;
    bus.flag_z = 1'b0; bus.flag_c = 1'b0;
    for (int k = 0; k < 20 && bus.cycle != 4'd5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("midadd_cycle",  32'(bus.cycle),      32'd5);
    chk("midadd_state",  32'(bus.state),      32'(STATE_RAM_B));
    chk("midadd_opcode", 32'(bus.opcode),     32'(OP_ADD));
    chk("midadd_ill",    32'(bus.illegal_op), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_idle("async_reset", 1'b0);
    bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #4 chk_idle("after_reset", 1'b0);
    bus.ready = 1'b1;
    @(posedge clk);
    #1 bus.ready = 1'b0;
    #4;
    chk("restart_cycle", 32'(bus.cycle), 32'd1);
    chk("restart_state", 32'(bus.state), 32'(STATE_FETCH_INST));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
